// File: rtl/s_memory_check.sv
// Read-back checker for the 256x8 S memory: sweeps 00..FF, compares each byte
// against address ^ EXPECT_XOR and reports pass, mismatch count and first failure.
module s_memory_check #(
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] EXPECT_XOR   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mem_q,
  output logic [7:0] mem_address,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] error_count,
  output logic       err_valid,
  output logic [7:0] first_err_addr,
  output logic [7:0] first_err_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]                   r_addr;
  logic [1:0]                   r_drain_cnt;
  logic [READ_LATENCY-1:0]      r_pv;
  logic [READ_LATENCY-1:0][7:0] r_pa;
  logic [8:0]                   r_err_cnt;
  logic                         r_err_valid;
  logic [7:0]                   r_first_addr;
  logic [7:0]                   r_first_data;
  logic                         r_pass;

  logic       w_drain_last;
  logic       w_accept;
  logic       w_mis;
  logic [8:0] w_err_next;

  assign w_drain_last = (r_drain_cnt == 2'(READ_LATENCY - 1));
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_mis        = r_pv[READ_LATENCY-1] &&
                        (mem_q != (r_pa[READ_LATENCY-1] ^ EXPECT_XOR));
  assign w_err_next   = (w_mis && (r_err_cnt != 9'd256)) ? r_err_cnt + 9'd1 : r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: if (r_addr == 8'hFF) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address counter doubles as the memory read address; it parks at FF in DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= 8'h00;
      r_drain_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          r_drain_cnt <= 2'd0;
          if (r_addr != 8'hFF) r_addr <= r_addr + 8'h01;
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 2'd1;
          if (w_drain_last) r_addr <= 8'h00;
        end
        default: r_addr <= 8'h00;
      endcase
    end
  end

  // {valid, addr} shadow of the memory's read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      r_pa <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
      r_pv[0] <= (r_state == S_ISSUE);
      r_pa[0] <= r_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt    <= 9'd0;
      r_err_valid  <= 1'b0;
      r_first_addr <= 8'h00;
      r_first_data <= 8'h00;
      r_pass       <= 1'b0;
    end else if (w_accept) begin
      r_err_cnt    <= 9'd0;
      r_err_valid  <= 1'b0;
      r_first_addr <= 8'h00;
      r_first_data <= 8'h00;
      r_pass       <= 1'b0;
    end else begin
      r_err_cnt <= w_err_next;
      if (w_mis && !r_err_valid) begin
        r_err_valid  <= 1'b1;
        r_first_addr <= r_pa[READ_LATENCY-1];
        r_first_data <= mem_q;
      end
      // The final compare lands on the same edge, so use the updated count.
      if ((r_state == S_DRAIN) && w_drain_last) r_pass <= (w_err_next == 9'd0);
    end
  end

  assign mem_address    = r_addr;
  assign busy           = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign pass           = r_pass;
  assign error_count    = r_err_cnt;
  assign err_valid      = r_err_valid;
  assign first_err_addr = r_first_addr;
  assign first_err_data = r_first_data;

endmodule
